// File: rtl/axi4s2data.sv
// AXI4-Stream sink for fixed-length packets: a two-entry skid buffer with registered tready
// forwards every beat to a valid/ready port while tlast framing is checked and counted.
module axi4s2data #(
    parameter int PACKET_BYTE = 1024*1024*4,
    parameter int DATA_WIDTH  = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    input  logic                  tvalid,
    output logic                  tready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  err_early_last,
    output logic                  err_missing_last,
    output logic                  err_sticky
);

    localparam int PACKET_LEN = PACKET_BYTE / (DATA_WIDTH / 8);
    localparam int BEAT_W     = $clog2(PACKET_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
    logic                  main_last_q,  main_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  skid_last_q,  skid_last_d;
    logic                  tready_q,     tready_d;
    logic [BEAT_W-1:0]     beat_cnt_q,   beat_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q,  pkt_count_d;
    logic [CNT_WIDTH-1:0]  err_count_q,  err_count_d;
    logic                  err_early_q,  err_early_d;
    logic                  err_missing_q, err_missing_d;
    logic                  err_sticky_q, err_sticky_d;
    logic                  accept;
    logic                  is_last_beat;

    assign accept       = tvalid && tready_q;
    assign is_last_beat = (beat_cnt_q == LAST_BEAT);

    // Skid buffer: main refills from skid first so order is kept; tready follows skid occupancy.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = tdata;
                    skid_last_d = tlast;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = tdata;
                main_last_d  = tlast;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = tdata;
            skid_last_d  = tlast;
        end

        tready_d = ~skid_valid_d;
    end

    // Framing check on every accepted beat; an error resynchronises the beat counter to zero.
    always_comb begin
        beat_cnt_d    = beat_cnt_q;
        pkt_count_d   = pkt_count_q;
        err_count_d   = err_count_q;
        err_early_d   = 1'b0;
        err_missing_d = 1'b0;
        err_sticky_d  = err_sticky_q;

        if (accept) begin
            if (tlast && is_last_beat) begin
                beat_cnt_d = '0;
                if (pkt_count_q != '1) pkt_count_d = pkt_count_q + 1'b1;
            end else if (tlast || is_last_beat) begin
                beat_cnt_d    = '0;
                err_early_d   = tlast;
                err_missing_d = !tlast;
                err_sticky_d  = 1'b1;
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q  <= 1'b0;
            main_data_q   <= '0;
            main_last_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            tready_q      <= 1'b0;
            beat_cnt_q    <= '0;
            pkt_count_q   <= '0;
            err_count_q   <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            main_valid_q  <= main_valid_d;
            main_data_q   <= main_data_d;
            main_last_q   <= main_last_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_last_q   <= skid_last_d;
            tready_q      <= tready_d;
            beat_cnt_q    <= beat_cnt_d;
            pkt_count_q   <= pkt_count_d;
            err_count_q   <= err_count_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign tready           = tready_q;
    assign out_valid        = main_valid_q;
    assign out_data         = main_data_q;
    assign out_last         = main_last_q;
    assign pkt_count        = pkt_count_q;
    assign err_count        = err_count_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;
    assign err_sticky       = err_sticky_q;

endmodule

// File: tb/tb_axi4s2data.sv
// Directed bench for axi4s2data with 4-beat packets; an output monitor checks every
// transfer against the in-order list of beats the bench saw accepted.
module tb_axi4s2data;

    logic        clk;
    logic        rst_n;
    logic [63:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pkt_count;
    logic [31:0] err_count;
    logic        err_early_last;
    logic        err_missing_last;
    logic        err_sticky;

    logic        ready_force;
    logic        rand_en;
    logic        rand_ready_q;
    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;
    int          total;
    int          bad;

    axi4s2data #(
        .PACKET_BYTE(32),
        .DATA_WIDTH (64),
        .CNT_WIDTH  (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tdata           (tdata),
        .tlast           (tlast),
        .tvalid          (tvalid),
        .tready          (tready),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pkt_count       (pkt_count),
        .err_count       (err_count),
        .err_early_last  (err_early_last),
        .err_missing_last(err_missing_last),
        .err_sticky      (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random consumer readiness, refreshed just after each rising edge.
    initial rand_ready_q = 1'b0;
    always @(posedge clk) begin
        #1;
        rand_ready_q = 1'($urandom_range(0, 1));
    end

    assign out_ready = rand_en ? rand_ready_q : ready_force;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each output transfer must be the oldest accepted beat not yet seen.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("[TB] FAIL mon_extra observed data=%0h expected no transfer", out_data);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("mon_data", out_data, mon_exp[63:0]);
                checkOutput("mon_last", 64'(out_last), 64'(mon_exp[64]));
            end
        end
    end

    task automatic applyReset();
        rst_n       = 1'b0;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        tdata       = '0;
        ready_force = 1'b0;
        rand_en     = 1'b0;
        step();
        step();
        exp_q.delete();
        rst_n = 1'b1;
        step();
        checkOutput("rst_exit_tready", 64'(tready), 1);
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic l, input bit chk_lat);
        int waited;
        waited = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && waited < 200) begin
            step();
            waited++;
        end
        total++;
        assert (tready) else begin
            bad++;
            $error("[TB] FAIL accept_timeout observed tready=%0b expected 1", tready);
        end
        step();
        exp_q.push_back({l, d});
        tvalid = 1'b0;
        if (chk_lat) begin
            checkOutput("lat_valid", 64'(out_valid), 1);
            checkOutput("lat_data", out_data, d);
        end
    endtask

    task automatic drain(input string tag);
        ready_force = 1'b1;
        rand_en     = 1'b0;
        tvalid      = 1'b0;
        repeat (6) step();
        checkOutput(tag, 64'(exp_q.size()), 0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        tdata       = '0;
        ready_force = 1'b0;
        rand_en     = 1'b0;

        // Reset state
        step();
        checkOutput("rst_tready", 64'(tready), 0);
        checkOutput("rst_out_valid", 64'(out_valid), 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_pkt_count", 64'(pkt_count), 0);
        checkOutput("rst_err_count", 64'(err_count), 0);
        checkOutput("rst_err_sticky", 64'(err_sticky), 0);

        // T1 normal flow
        applyReset();
        ready_force = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(64'(i), (i == 4) || (i == 8), 1'b1);
            checkOutput("t1_out_last", 64'(out_last), 64'((i == 4) || (i == 8)));
        end
        checkOutput("t1_pkt_count", 64'(pkt_count), 2);
        checkOutput("t1_err_count", 64'(err_count), 0);
        checkOutput("t1_err_sticky", 64'(err_sticky), 0);
        drain("t1_drain");

        // T2 backpressure
        applyReset();
        ready_force = 1'b0;
        tvalid = 1'b1;
        tlast  = 1'b0;
        tdata  = 64'd1;
        step();
        exp_q.push_back({1'b0, 64'd1});
        checkOutput("t2_out_valid", 64'(out_valid), 1);
        checkOutput("t2_out_data1", out_data, 1);
        checkOutput("t2_tready_after1", 64'(tready), 1);
        tdata = 64'd2;
        step();
        exp_q.push_back({1'b0, 64'd2});
        checkOutput("t2_tready_after2", 64'(tready), 0);
        tdata = 64'd3;
        step();
        checkOutput("t2_tready_full", 64'(tready), 0);
        checkOutput("t2_hold_data", out_data, 1);
        step();
        checkOutput("t2_hold_data2", out_data, 1);
        ready_force = 1'b1;
        step();
        checkOutput("t2_tready_back", 64'(tready), 1);
        checkOutput("t2_out_data2", out_data, 2);
        step();
        exp_q.push_back({1'b0, 64'd3});
        checkOutput("t2_out_data3", out_data, 3);
        applyStimulus(64'd4, 1'b1, 1'b0);
        checkOutput("t2_pkt_count", 64'(pkt_count), 1);
        drain("t2_drain");

        // T3 early tlast
        applyReset();
        ready_force = 1'b1;
        applyStimulus(64'h11, 1'b0, 1'b0);
        applyStimulus(64'h12, 1'b1, 1'b0);
        checkOutput("t3_early_pulse", 64'(err_early_last), 1);
        checkOutput("t3_missing_quiet", 64'(err_missing_last), 0);
        checkOutput("t3_err_count", 64'(err_count), 1);
        checkOutput("t3_err_sticky", 64'(err_sticky), 1);
        step();
        checkOutput("t3_early_cleared", 64'(err_early_last), 0);
        for (int i = 1; i <= 4; i++) applyStimulus(64'(32'h20 + i), i == 4, 1'b0);
        checkOutput("t3_pkt_count", 64'(pkt_count), 1);
        checkOutput("t3_err_count_after", 64'(err_count), 1);
        checkOutput("t3_sticky_held", 64'(err_sticky), 1);
        drain("t3_drain");

        // T4 missing tlast
        applyReset();
        ready_force = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(64'(32'h40 + i), 1'b0, 1'b0);
        checkOutput("t4_missing_pulse", 64'(err_missing_last), 1);
        checkOutput("t4_early_quiet", 64'(err_early_last), 0);
        checkOutput("t4_err_count", 64'(err_count), 1);
        checkOutput("t4_pkt_count0", 64'(pkt_count), 0);
        step();
        checkOutput("t4_missing_cleared", 64'(err_missing_last), 0);
        for (int i = 5; i <= 8; i++) applyStimulus(64'(32'h40 + i), i == 8, 1'b0);
        checkOutput("t4_pkt_count", 64'(pkt_count), 1);
        checkOutput("t4_err_count_after", 64'(err_count), 1);
        drain("t4_drain");

        // T5 reset while the buffer is full mid-packet
        applyReset();
        ready_force = 1'b1;
        applyStimulus(64'h51, 1'b1, 1'b0);
        step();
        ready_force = 1'b0;
        applyStimulus(64'h52, 1'b0, 1'b0);
        applyStimulus(64'h53, 1'b0, 1'b0);
        checkOutput("t5_full_tready", 64'(tready), 0);
        checkOutput("t5_full_valid", 64'(out_valid), 1);
        checkOutput("t5_pre_err_count", 64'(err_count), 1);
        checkOutput("t5_pre_sticky", 64'(err_sticky), 1);
        rst_n = 1'b0;
        step();
        checkOutput("t5_rst_valid", 64'(out_valid), 0);
        checkOutput("t5_rst_tready", 64'(tready), 0);
        checkOutput("t5_rst_data", out_data, 0);
        checkOutput("t5_rst_err_count", 64'(err_count), 0);
        checkOutput("t5_rst_pkt_count", 64'(pkt_count), 0);
        checkOutput("t5_rst_sticky", 64'(err_sticky), 0);
        exp_q.delete();
        rst_n = 1'b1;
        step();
        checkOutput("t5_exit_tready", 64'(tready), 1);
        checkOutput("t5_exit_valid", 64'(out_valid), 0);
        ready_force = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(64'(32'h60 + i), i == 4, 1'b0);
        checkOutput("t5_pkt_count", 64'(pkt_count), 1);
        checkOutput("t5_err_count", 64'(err_count), 0);
        drain("t5_drain");

        // T6 random gaps and backpressure
        applyReset();
        rand_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) step();
                applyStimulus({$urandom, $urandom}, b == 3, 1'b0);
            end
        end
        drain("t6_drain");
        checkOutput("t6_pkt_count", 64'(pkt_count), 1000);
        checkOutput("t6_err_count", 64'(err_count), 0);
        checkOutput("t6_err_sticky", 64'(err_sticky), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
